sync_fifo_flagged: RTL and testbench

- Parametrised single-clock FIFO; successor to the fixed 8-bit/4-deep synchronous FIFO.
- Adds:
  - generic width and depth
  - occupancy count
  - programmable almost-full and almost-empty thresholds
  - overflow and underflow error pulses
  - selectable first-word-fall-through (FWFT) read mode
- Sits between producer and consumer datapaths in one clock domain; used wherever early back-pressure or error detection is needed.

---
 rtl/sync_fifo_flagged.sv | 94 +++++++++
 tb/tb_sync_fifo_flagged.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// overflow/underflow error pulses and an optional first-word-fall-through read port.
module sync_fifo_flagged #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4,
  parameter bit FWFT          = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_LVL   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_LVL  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_LVL = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [CW-1:0]         next_count;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;

  always_comb begin
    next_count = count;
    case ({wr_acc, rd_acc})
      2'b10:   next_count = count + CW'(1);
      2'b01:   next_count = count - CW'(1);
      default: next_count = count;
    endcase
  end

  // Flags are registered from next_count so they change in the same cycle as count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count        <= next_count;
      full         <= (next_count == FULL_LVL);
      empty        <= (next_count == '0);
      almost_full  <= (next_count >= AFULL_LVL);
      almost_empty <= (next_count <= AEMPTY_LVL);
      overflow     <= wr_en && full && !rd_en;
      underflow    <= rd_en && empty;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem[wr_ptr] <= wr_data;
  end

  generate
    if (FWFT) begin : g_fwft
      assign rd_data = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (reset)       rd_q <= '0;
        else if (rd_acc) rd_q <= mem[rd_ptr];
      end
      assign rd_data = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Directed table-driven bench for sync_fifo_flagged: a standard-read 16-deep
// instance and a first-word-fall-through 4-deep instance.
module tb_sync_fifo_flagged;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, rd_en;
  logic [7:0] wr_data, rd_data;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       fwr_en, frd_en;
  logic [7:0] fwr_data, frd_data;
  logic       ffull, fempty, falmost_full, falmost_empty, foverflow, funderflow;
  logic [2:0] fcount;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       rd;
    logic [4:0] cnt;
    logic       full_e, empty_e, af_e, ae_e, ovf_e, udf_e;
    logic [7:0] rdata_e;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  sync_fifo_flagged #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(12),
                      .AEMPTY_THRESH(4), .FWFT(1'b0)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flagged #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_THRESH(3),
                      .AEMPTY_THRESH(1), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .reset(reset), .wr_en(fwr_en), .wr_data(fwr_data), .rd_en(frd_en),
    .rd_data(frd_data), .full(ffull), .empty(fempty), .almost_full(falmost_full),
    .almost_empty(falmost_empty), .count(fcount), .overflow(foverflow), .underflow(funderflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r);
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic applyFwft(input logic w, input logic [7:0] d, input logic r);
    fwr_en = w; fwr_data = d; frd_en = r;
    @(posedge clk); #1;
    fwr_en = 1'b0; frd_en = 1'b0;
  endtask

  task automatic addVec(input logic w, input logic [7:0] d, input logic r, input logic [4:0] c,
                        input logic fu, input logic em, input logic af, input logic ae,
                        input logic ov, input logic ud, input logic [7:0] rdv);
    vec_t v;
    v.wr = w; v.data = d; v.rd = r; v.cnt = c;
    v.full_e = fu; v.empty_e = em; v.af_e = af; v.ae_e = ae;
    v.ovf_e = ov; v.udf_e = ud; v.rdata_e = rdv;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] sb[$];
    logic [7:0] nextData;
    logic [7:0] popped;
    int         modelCnt;
    logic       w, r, wAcc, rAcc;

    reset = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    fwr_en = 1'b0; frd_en = 1'b0; fwr_data = '0;

    // Fill to full, one overflow, drain, one underflow.
    for (int i = 1; i <= 16; i++)
      addVec(1'b1, 8'(i), 1'b0, 5'(i), i == 16, 1'b0, i >= 12, i <= 4, 1'b0, 1'b0, 8'h00);
    addVec(1'b1, 8'hAA, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    addVec(1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 16; k++)
      addVec(1'b0, 8'h00, 1'b1, 5'(16 - k), 1'b0, k == 16, (16 - k) >= 12, (16 - k) <= 4,
             1'b0, 1'b0, 8'(k));
    addVec(1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
    addVec(1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10);

    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_empty", 32'(empty), 32'd1);
    checkOutput("reset_aempty", 32'(almost_empty), 32'd1);
    checkOutput("reset_full", 32'(full), 32'd0);
    checkOutput("reset_afull", 32'(almost_full), 32'd0);
    checkOutput("reset_ovf", 32'(overflow), 32'd0);
    checkOutput("reset_udf", 32'(underflow), 32'd0);
    checkOutput("reset_rdata", 32'(rd_data), 32'd0);
    checkOutput("reset_fwft_empty", 32'(fempty), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].wr, vecs[i].data, vecs[i].rd);
      checkOutput($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      checkOutput($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].full_e));
      checkOutput($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].empty_e));
      checkOutput($sformatf("v%0d_afull", i), 32'(almost_full), 32'(vecs[i].af_e));
      checkOutput($sformatf("v%0d_aempty", i), 32'(almost_empty), 32'(vecs[i].ae_e));
      checkOutput($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf_e));
      checkOutput($sformatf("v%0d_udf", i), 32'(underflow), 32'(vecs[i].udf_e));
      checkOutput($sformatf("v%0d_rdata", i), 32'(rd_data), 32'(vecs[i].rdata_e));
    end

    // Write and read together while full: count stays, 0x55 lands behind the older words.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0);
    checkOutput("prefill_full", 32'(full), 32'd1);
    applyStimulus(1'b1, 8'h55, 1'b1);
    checkOutput("simul_full_count", 32'(count), 32'd16);
    checkOutput("simul_full_ovf", 32'(overflow), 32'd0);
    checkOutput("simul_full_rdata", 32'(rd_data), 32'h20);
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("drain_rdata%0d", i), 32'(rd_data), 32'(8'h20 + i));
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drain_last_0x55", 32'(rd_data), 32'h55);
    checkOutput("drain_last_empty", 32'(empty), 32'd1);

    // Write and read together while empty: write lands, read is rejected.
    applyStimulus(1'b1, 8'h77, 1'b1);
    checkOutput("simul_empty_count", 32'(count), 32'd1);
    checkOutput("simul_empty_udf", 32'(underflow), 32'd1);
    checkOutput("simul_empty_rdata_hold", 32'(rd_data), 32'h55);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("read_0x77", 32'(rd_data), 32'h77);
    checkOutput("read_0x77_count", 32'(count), 32'd0);

    // Reset in the middle of a fill.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
    checkOutput("midfill_count", 32'(count), 32'd5);
    reset = 1'b1;
    applyStimulus(1'b1, 8'hEE, 1'b0);
    reset = 1'b0;
    checkOutput("midreset_count", 32'(count), 32'd0);
    checkOutput("midreset_empty", 32'(empty), 32'd1);
    checkOutput("midreset_rdata", 32'(rd_data), 32'd0);
    applyStimulus(1'b1, 8'h99, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("midreset_ptr_align", 32'(rd_data), 32'h99);
    checkOutput("midreset_drained", 32'(empty), 32'd1);

    // Random traffic across pointer wrap, checked against a queue model.
    modelCnt = 0;
    nextData = 8'h01;
    for (int c = 0; c < 40; c++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      wAcc = w && (modelCnt < 16 || r);
      rAcc = r && (modelCnt > 0);
      applyStimulus(w, nextData, r);
      if (rAcc) begin
        popped = sb.pop_front();
        checkOutput($sformatf("rand%0d_rdata", c), 32'(rd_data), 32'(popped));
      end
      if (wAcc) begin
        sb.push_back(nextData);
        nextData++;
      end
      modelCnt = modelCnt + (wAcc ? 1 : 0) - (rAcc ? 1 : 0);
      checkOutput($sformatf("rand%0d_count", c), 32'(count), 32'(modelCnt));
      checkOutput($sformatf("rand%0d_empty", c), 32'(empty), 32'(modelCnt == 0));
      checkOutput($sformatf("rand%0d_udf", c), 32'(underflow), 32'(r && !rAcc));
    end

    // First-word-fall-through instance.
    applyFwft(1'b1, 8'h5D, 1'b0);
    checkOutput("fwft_first_word", 32'(frd_data), 32'h5D);
    checkOutput("fwft_first_count", 32'(fcount), 32'd1);
    checkOutput("fwft_first_empty", 32'(fempty), 32'd0);
    applyFwft(1'b1, 8'hD4, 1'b0);
    applyFwft(1'b1, 8'hF3, 1'b0);
    applyFwft(1'b1, 8'h0D, 1'b0);
    checkOutput("fwft_full", 32'(ffull), 32'd1);
    checkOutput("fwft_afull", 32'(falmost_full), 32'd1);
    checkOutput("fwft_head_hold", 32'(frd_data), 32'h5D);
    applyFwft(1'b0, 8'h00, 1'b1);
    checkOutput("fwft_pop1", 32'(frd_data), 32'hD4);
    applyFwft(1'b0, 8'h00, 1'b1);
    checkOutput("fwft_pop2", 32'(frd_data), 32'hF3);
    applyFwft(1'b0, 8'h00, 1'b1);
    checkOutput("fwft_pop3", 32'(frd_data), 32'h0D);
    checkOutput("fwft_aempty", 32'(falmost_empty), 32'd1);
    applyFwft(1'b0, 8'h00, 1'b1);
    checkOutput("fwft_pop4_empty", 32'(fempty), 32'd1);
    checkOutput("fwft_pop4_count", 32'(fcount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
